// File: rtl/round_robin_hold_arbiter_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Holds the FSM state encoding and the one-hot to binary index conversion.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int MAX_VEC_W = 64;

    function automatic int unsigned onehot_to_idx(input logic [MAX_VEC_W-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_VEC_W; i++) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Combinational fixed-priority picker: the lowest-index set request wins.
// Output is one-hot, or zero when nothing is requested.
module fixed_priority_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);

    // Isolates the lowest set bit of req.
    assign gnt = req & ~(req - NUM_PORTS'(1));

endmodule

// File: rtl/round_robin_hold_arbiter.sv
// Rotating-priority arbiter with grant hold: the holder keeps the grant up to
// MAX_HOLD cycles (0 = unlimited), then is demoted to lowest priority.
module round_robin_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 8,
    localparam int PTR_W    = $clog2(NUM_PORTS),
    localparam int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [PTR_W-1:0]     gnt_id_o
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    arb_state_t           state_q;
    logic [NUM_PORTS-1:0] gnt_q;
    logic                 valid_q;
    logic [PTR_W-1:0]     id_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     hold_cnt_q;

    logic [PTR_W-1:0]     arb_ptr;
    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] masked_gnt;
    logic [NUM_PORTS-1:0] plain_gnt;
    logic [NUM_PORTS-1:0] pick;
    logic [PTR_W-1:0]     pick_id;
    logic                 hold_done;

    // On a release the holder's successor becomes top priority this same cycle,
    // so the handoff needs no idle bubble.
    always_comb begin
        arb_ptr = ptr_q;
        if (state_q == ARB_GRANT) begin
            arb_ptr = (id_q == PTR_W'(NUM_PORTS - 1)) ? '0 : id_q + PTR_W'(1);
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            mask[i] = (i >= int'(arb_ptr));
        end
    end

    fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_masked_pick (
        .req (req_i & mask),
        .gnt (masked_gnt)
    );

    fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_plain_pick (
        .req (req_i),
        .gnt (plain_gnt)
    );

    assign pick      = (|masked_gnt) ? masked_gnt : plain_gnt;
    assign pick_id   = PTR_W'(onehot_to_idx(MAX_VEC_W'(pick)));
    assign hold_done = !req_i[id_q] || ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT));

    // NOTE: reset is synchronous (sampled on the clock edge like any other input),
    // and every state register is updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|req_i) begin
                        state_q    <= ARB_GRANT;
                        gnt_q      <= pick;
                        valid_q    <= 1'b1;
                        id_q       <= pick_id;
                        hold_cnt_q <= CNT_W'(1);
                    end
                end
                ARB_GRANT: begin
                    if (hold_done) begin
                        ptr_q <= arb_ptr;
                        if (|pick) begin
                            gnt_q      <= pick;
                            valid_q    <= 1'b1;
                            id_q       <= pick_id;
                            hold_cnt_q <= CNT_W'(1);
                        end else begin
                            state_q    <= ARB_IDLE;
                            gnt_q      <= '0;
                            valid_q    <= 1'b0;
                            id_q       <= '0;
                            hold_cnt_q <= '0;
                        end
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    id_q    <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign gnt_id_o    = id_q;

endmodule

// File: tb/tb_round_robin_hold_arbiter.sv
// Self-checking bench: one arbiter with MAX_HOLD=4 driven from a vector table,
// plus a MAX_HOLD=1 arbiter exercised with a hand-written rotation sequence.
module tb_round_robin_hold_arbiter;

    logic       clk;
    logic       resetn;
    logic [3:0] req, req1;
    logic [3:0] gnt, gnt1;
    logic       gv, gv1;
    logic [1:0] gid, gid1;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [3:0] g1;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    round_robin_hold_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_valid_o (gv),
        .gnt_id_o    (gid)
    );

    round_robin_hold_arbiter #(.NUM_PORTS(4), .MAX_HOLD(1)) dut1 (
        .clk         (clk),
        .resetn      (resetn),
        .req_i       (req1),
        .gnt_o       (gnt1),
        .gnt_valid_o (gv1),
        .gnt_id_o    (gid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] e);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, queue the expectation, then compare after the edge.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] r1,
                        input logic [3:0] e, input logic [3:0] e1, input int tag);
        exp_t x;
        @(negedge clk);
        resetn = rst;
        req    = r;
        req1   = r1;
        x.g    = e;
        x.g1   = e1;
        x.tag  = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check($sformatf("gnt[%0d]", x.tag),    32'(gnt),  32'(x.g));
        check($sformatf("id[%0d]", x.tag),     32'(gid),  32'(idx_of(x.g)));
        check($sformatf("valid[%0d]", x.tag),  32'(gv),   32'(|x.g));
        check($sformatf("gnt1[%0d]", x.tag),   32'(gnt1), 32'(x.g1));
        check($sformatf("id1[%0d]", x.tag),    32'(gid1), 32'(idx_of(x.g1)));
        check($sformatf("valid1[%0d]", x.tag), 32'(gv1),  32'(|x.g1));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            check("onehot0_1", 32'($onehot0(gnt1)), 32'd1);
        end
    end

    initial begin
        resetn = 1'b0;
        req    = 4'b0000;
        req1   = 4'b0000;

        // Reset held with all requests high, then 1-cycle grant latency.
        repeat (3) add(1'b0, 4'b1111, 4'b0000);
        add(1'b1, 4'b1111, 4'b0001);
        add(1'b0, 4'b0000, 4'b0000);

        // Constant 1011: four-cycle tenures, rotating with no gap.
        repeat (4) add(1'b1, 4'b1011, 4'b0001);
        repeat (4) add(1'b1, 4'b1011, 4'b0010);
        repeat (4) add(1'b1, 4'b1011, 4'b1000);
        add(1'b1, 4'b1011, 4'b0001);
        add(1'b0, 4'b0000, 4'b0000);

        // Holder drops its request: immediate handoff.
        repeat (2) add(1'b1, 4'b0110, 4'b0010);
        repeat (2) add(1'b1, 4'b0100, 4'b0100);
        add(1'b0, 4'b0000, 4'b0000);

        // Lone requester on the top port: forced release restarts its tenure.
        repeat (9) add(1'b1, 4'b1000, 4'b1000);
        add(1'b0, 4'b0000, 4'b0000);

        // Drop to idle, pointer retained at 2.
        repeat (2) add(1'b1, 4'b0010, 4'b0010);
        add(1'b1, 4'b0000, 4'b0000);
        add(1'b1, 4'b1001, 4'b1000);
        add(1'b0, 4'b0000, 4'b0000);

        // Mid-tenure reset clears the pointer.
        add(1'b1, 4'b0110, 4'b0010);
        repeat (2) add(1'b1, 4'b0100, 4'b0100);
        add(1'b0, 4'b0100, 4'b0000);
        add(1'b1, 4'b0101, 4'b0001);

        // Port requests then drops before ever being granted: it is skipped.
        add(1'b0, 4'b0000, 4'b0000);
        add(1'b1, 4'b0001, 4'b0001);
        add(1'b1, 4'b0101, 4'b0001);
        add(1'b1, 4'b0001, 4'b0001);
        add(1'b1, 4'b0001, 4'b0001);
        add(1'b1, 4'b0000, 4'b0000);

        mon_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].req, 4'b0000, vecs[i].exp, 4'b0000, i);
        end

        // MAX_HOLD=1: constant 1011 rotates every cycle.
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 100);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b0001, 101);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b0010, 102);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b1000, 103);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b0001, 104);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b0010, 105);
        step(1'b1, 4'b0000, 4'b1011, 4'b0000, 4'b1000, 106);
        // Single requester under MAX_HOLD=1 keeps being re-granted.
        step(1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 107);
        step(1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 108);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 109);

        if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
